// File: rtl/icap_stream_writer_pkg.sv
// Shared types and helpers for the ICAP bitstream writer: FSM states,
// error cause codes and the per-byte bit reversal ICAP expects.
package icap_stream_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WAIT_DONE,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_PRERROR = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // ICAP takes each configuration byte with its bit order reversed.
   function automatic logic [31:0] bit_swap32(input logic [31:0] word);
      logic [31:0] swapped;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            swapped[8*b+i] = word[8*b+7-i];
         end
      end
      return swapped;
   endfunction

endpackage

// File: rtl/icap_sync_fifo.sv
// Single-clock FIFO buffering bitstream words (plus TLAST) ahead of ICAP.
module icap_sync_fifo
   import icap_stream_writer_pkg::*;
#(
   parameter int WIDTH = 36,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/icap_stream_writer.sv
// Streams a buffered bitstream into the ICAP port and tracks completion,
// PRERROR and PRDONE timeout.
module icap_stream_writer
   import icap_stream_writer_pkg::*;
#(
   parameter int FIFO_DEPTH     = 16,
   parameter int BIT_SWAP       = 1,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   input  logic        clear,
   output logic        icap_csib,
   output logic        icap_rdwrb,
   output logic [31:0] icap_i,
   input  logic        icap_avail,
   input  logic        icap_prdone,
   input  logic        icap_prerror,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [31:0] word_count
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic          rdy_en;
   logic [TW-1:0] timer;
   logic          beat;
   logic          push;
   logic          pop;
   logic [35:0]   fifo_q;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_last;
   logic [31:0]   drive_word;

   // rdy_en keeps TREADY low until the first edge after reset releases.
   assign s_tready   = rdy_en && !fifo_full && (state != ST_WAIT_DONE) && (state != ST_DONE);
   assign beat       = s_tvalid && s_tready;
   assign push       = beat && (state != ST_ERR);
   assign pop        = (state == ST_WRITE) && !fifo_empty && icap_avail && !icap_prerror;
   assign fifo_last  = |fifo_q[35:32];
   assign drive_word = (BIT_SWAP != 0) ? bit_swap32(fifo_q[31:0]) : fifo_q[31:0];

   assign icap_rdwrb = 1'b0;
   assign busy       = (state == ST_WRITE) || (state == ST_WAIT_DONE);
   assign done       = (state == ST_DONE);
   assign error      = (state == ST_ERR);

   icap_sync_fifo #(
      .WIDTH (36),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (state == ST_ERR),
      .push      (push),
      .push_data ({3'b000, s_tlast, s_tdata}),
      .pop       (pop),
      .pop_data  (fifo_q),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // PRERROR is tested first so it wins over PRDONE and timeout in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rdy_en     <= 1'b0;
         icap_csib  <= 1'b1;
         icap_i     <= '0;
         err_code   <= ERR_NONE;
         word_count <= '0;
         timer      <= '0;
      end else begin
         rdy_en    <= 1'b1;
         icap_csib <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (beat) begin
                  state      <= ST_WRITE;
                  word_count <= '0;
               end
            end
            ST_WRITE: begin
               if (icap_prerror) begin
                  state    <= ST_ERR;
                  err_code <= ERR_PRERROR;
               end else if (pop) begin
                  icap_csib <= 1'b0;
                  icap_i    <= drive_word;
                  if (word_count != 32'hFFFF_FFFF) word_count <= word_count + 32'd1;
                  if (fifo_last) begin
                     state <= ST_WAIT_DONE;
                     timer <= '0;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (icap_prerror) begin
                  state    <= ST_ERR;
                  err_code <= ERR_PRERROR;
               end else if (icap_prdone) begin
                  state <= ST_DONE;
               end else if (timer == TIMER_LAST) begin
                  state    <= ST_ERR;
                  err_code <= ERR_TIMEOUT;
               end else begin
                  timer <= timer + {{(TW-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            ST_ERR: begin
               if (clear) begin
                  state    <= ST_IDLE;
                  err_code <= ERR_NONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icap_stream_writer.sv
// Directed self-checking bench for icap_stream_writer (depth 16, swap on, 16-cycle timeout).
module tb_icap_stream_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic        clear = 1'b0;
   logic        icap_csib;
   logic        icap_rdwrb;
   logic [31:0] icap_i;
   logic        icap_avail = 1'b0;
   logic        icap_prdone = 1'b0;
   logic        icap_prerror = 1'b0;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;
   logic [31:0] word_count;

   int          checkCount = 0;
   int          passCount = 0;
   int          cyc = 0;
   logic [31:0] wq[$];
   int          wc[$];

   icap_stream_writer #(
      .FIFO_DEPTH     (16),
      .BIT_SWAP       (1),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready),
      .s_tlast      (s_tlast),
      .clear        (clear),
      .icap_csib    (icap_csib),
      .icap_rdwrb   (icap_rdwrb),
      .icap_i       (icap_i),
      .icap_avail   (icap_avail),
      .icap_prdone  (icap_prdone),
      .icap_prerror (icap_prerror),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .err_code     (err_code),
      .word_count   (word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every CSIB-low cycle is one ICAP write; log its data and cycle number.
   always begin
      @(posedge clk);
      #1;
      if (!icap_csib) begin
         wq.push_back(icap_i);
         wc.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] swapModel(input logic [31:0] w);
      logic [31:0] r;
      logic [7:0]  b;
      for (int k = 0; k < 4; k++) begin
         b = w[8*k +: 8];
         r[8*k +: 8] = {<<{b}};
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   // Called at a negedge; returns at the negedge after the beat is accepted or the budget runs out.
   task automatic applyStimulus(input logic [31:0] data, input logic last, input int budget, output bit ok);
      s_tdata  = data;
      s_tlast  = last;
      s_tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (s_tready) ok = 1'b1;
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic waitWrites(input int n, input int budget);
      for (int i = 0; i < budget && wq.size() < n; i++) @(negedge clk);
      checkOutput("write_count", wq.size(), n);
   endtask

   task automatic finishTransfer();
      icap_prdone = 1'b1;
      @(negedge clk);
      icap_prdone = 1'b0;
      checkOutput("done_pulse", done, 1);
      @(negedge clk);
      checkOutput("done_low", done, 0);
      checkOutput("idle_not_busy", busy, 0);
   endtask

   initial begin
      bit          ok;
      int          startCyc;
      int          accepted;
      int          nBefore;
      int          errCyc;
      logic [31:0] exp8 [8];

      exp8 = '{32'h80, 32'h40, 32'hC0, 32'h20, 32'hA0, 32'h60, 32'hE0, 32'h10};

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_csib", icap_csib, 1);
      checkOutput("rst_rdwrb", icap_rdwrb, 0);
      checkOutput("rst_icap_i", icap_i, 0);
      checkOutput("rst_tready", s_tready, 0);
      checkOutput("rst_status", {busy, done, error}, 0);
      checkOutput("rst_err_code", err_code, 0);
      checkOutput("rst_word_count", word_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("tready_after_rst", s_tready, 1);

      // Three-word stream with bit swap and PRDONE five cycles after the last write
      $display("[TB] three-word stream");
      icap_avail = 1'b1;
      startCyc = cyc;
      applyStimulus(32'hAA995566, 1'b0, 10, ok);
      applyStimulus(32'h20000000, 1'b0, 10, ok);
      applyStimulus(32'h30008001, 1'b1, 10, ok);
      waitWrites(3, 20);
      checkOutput("busy_wait_done", busy, 1);
      checkOutput("tready_wait_done", s_tready, 0);
      if (wq.size() == 3) begin
         checkOutput("latency", wc[0] - startCyc, 2);
         checkOutput("back_to_back", wc[2] - wc[0], 2);
         checkOutput("word0", wq[0], 32'h5599AA66);
         checkOutput("word1", wq[1], 32'h04000000);
         checkOutput("word2", wq[2], 32'h0C000180);
      end
      repeat (4) @(negedge clk);
      finishTransfer();
      checkOutput("count_3", word_count, 3);

      // Eight words with ICAP_AVAIL low for four cycles mid-stream
      $display("[TB] avail stall");
      wq.delete();
      wc.delete();
      nBefore = 0;
      fork
         begin
            for (int i = 1; i <= 8; i++) applyStimulus(32'(i), (i == 8), 20, ok);
         end
         begin
            repeat (3) @(negedge clk);
            icap_avail = 1'b0;
            nBefore = wq.size();
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               checkOutput("stall_csib", icap_csib, 1);
            end
            checkOutput("stall_no_write", wq.size(), nBefore);
            icap_avail = 1'b1;
         end
      join
      checkOutput("stall_before", nBefore, 2);
      waitWrites(8, 40);
      finishTransfer();
      for (int i = 0; i < 8 && i < wq.size(); i++) checkOutput("stall_word", wq[i], exp8[i]);
      checkOutput("count_8", word_count, 8);

      // Fill the FIFO with ICAP_AVAIL low, then release
      $display("[TB] fifo full backpressure");
      wq.delete();
      wc.delete();
      icap_avail = 1'b0;
      accepted = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(32'h0F1E2D3C + 32'(i) * 32'h01010101, 1'b0, 1, ok);
         accepted += int'(ok);
      end
      checkOutput("fill_accepted", accepted, 16);
      checkOutput("full_tready", s_tready, 0);
      fork
         begin
            for (int i = 16; i < 20; i++) begin
               applyStimulus(32'h0F1E2D3C + 32'(i) * 32'h01010101, (i == 19), 200, ok);
               checkOutput("release_accept", ok, 1);
            end
         end
         begin
            repeat (3) @(negedge clk);
            checkOutput("full_hold", s_tready, 0);
            checkOutput("full_no_write", wq.size(), 0);
            icap_avail = 1'b1;
         end
      join
      waitWrites(20, 100);
      finishTransfer();
      for (int i = 0; i < 20 && i < wq.size(); i++)
         checkOutput("full_word", wq[i], swapModel(32'h0F1E2D3C + 32'(i) * 32'h01010101));
      checkOutput("count_20", word_count, 20);

      // PRERROR on the second write, beats dropped in ERR, CLEAR, then a clean stream
      $display("[TB] prerror and clear");
      wq.delete();
      wc.delete();
      fork
         begin
            applyStimulus(32'h00000010, 1'b0, 10, ok);
            applyStimulus(32'h00000020, 1'b0, 10, ok);
            applyStimulus(32'h00000030, 1'b0, 10, ok);
            applyStimulus(32'h00000040, 1'b1, 10, ok);
         end
         begin
            waitWrites(2, 20);
            icap_prerror = 1'b1;
            @(negedge clk);
            icap_prerror = 1'b0;
         end
      join
      checkOutput("err_level", error, 1);
      checkOutput("err_code_prerror", err_code, 2'b01);
      checkOutput("err_not_busy", busy, 0);
      applyStimulus(32'h00000050, 1'b0, 10, ok);
      checkOutput("err_accepts", ok, 1);
      applyStimulus(32'h00000060, 1'b1, 10, ok);
      repeat (3) @(negedge clk);
      checkOutput("err_dropped", wq.size(), 2);
      checkOutput("err_still", error, 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checkOutput("clear_error", error, 0);
      checkOutput("clear_code", err_code, 0);
      wq.delete();
      wc.delete();
      applyStimulus(32'h00000001, 1'b0, 10, ok);
      applyStimulus(32'h00000002, 1'b1, 10, ok);
      waitWrites(2, 20);
      finishTransfer();
      if (wq.size() == 2) begin
         checkOutput("after_clear_w0", wq[0], 32'h00000080);
         checkOutput("after_clear_w1", wq[1], 32'h00000040);
      end
      checkOutput("count_2", word_count, 2);

      // No PRDONE: timeout lands 16 cycles after the last write
      $display("[TB] prdone timeout");
      wq.delete();
      wc.delete();
      applyStimulus(32'hFFFF0000, 1'b1, 10, ok);
      waitWrites(1, 10);
      errCyc = 0;
      for (int i = 0; i < 40 && err_code != 2'b10; i++) begin
         @(negedge clk);
         errCyc = cyc;
      end
      checkOutput("timeout_code", err_code, 2'b10);
      if (wc.size() == 1) begin
         checkOutput("timeout_cycles", errCyc - wc[0], 16);
         checkOutput("timeout_word", wq[0], 32'hFFFF0000);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checkOutput("timeout_cleared", err_code, 0);

      // Reset asserted mid-stream
      $display("[TB] reset mid-stream");
      wq.delete();
      wc.delete();
      applyStimulus(32'hA1A1A1A1, 1'b0, 10, ok);
      applyStimulus(32'hB2B2B2B2, 1'b0, 10, ok);
      applyStimulus(32'hC3C3C3C3, 1'b0, 10, ok);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_csib", icap_csib, 1);
      checkOutput("midrst_icap_i", icap_i, 0);
      checkOutput("midrst_tready", s_tready, 0);
      checkOutput("midrst_status", {busy, done, error, err_code}, 0);
      checkOutput("midrst_count", word_count, 0);
      repeat (3) @(negedge clk);
      checkOutput("midrst_no_write", wq.size(), 2);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midrst_tready_back", s_tready, 1);
      checkOutput("midrst_idle", busy, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
